// File: rtl/pc_if_id.sv
// pc_if_id: fetch PC register and IF/ID pipeline register with redirect/stall handling.
// Define DELAY_SLOT_EN to keep the instruction after a redirect (one MIPS delay slot) instead of squashing it.
module pc_if_id #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr_mem_data,
  input  logic        stall,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus_4,
  output logic        if_id_valid,
  output logic [15:0] redirect_count
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_instr, r_pc4, w_pc_nxt, w_instr_nxt, w_pc4_nxt, w_pc_plus_4, w_rd_instr;
  logic        r_valid, w_valid_nxt, w_redirect, w_rd_valid;
  logic [15:0] r_cnt;
  assign w_pc_plus_4 = r_pc + 32'd4;
`ifdef DELAY_SLOT_EN
  assign w_rd_instr = instr_mem_data;
  assign w_rd_valid = 1'b1;
`else
  assign w_rd_instr = NOP_INSTR;
  assign w_rd_valid = 1'b0;
`endif
  // branch beats stall beats jump; a stalled jump is simply re-presented later
  always_comb begin
    w_state_nxt = RUN;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_pc4_nxt   = r_pc4;
    w_valid_nxt = r_valid;
    w_redirect  = 1'b0;
    if (r_state == RUN) begin
      w_redirect  = branch_taken || (!stall && jump_taken);
      w_pc_nxt    = branch_taken ? branch_target : stall ? r_pc : jump_taken ? jump_target : w_pc_plus_4;
      w_instr_nxt = stall && !branch_taken ? r_instr : w_redirect ? w_rd_instr : instr_mem_data;
      w_pc4_nxt   = stall && !branch_taken ? r_pc4 : w_pc_plus_4;
      w_valid_nxt = stall && !branch_taken ? r_valid : w_redirect ? w_rd_valid : 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
      r_cnt   <= 16'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pc4   <= w_pc4_nxt;
      r_valid <= w_valid_nxt;
      r_cnt   <= (w_redirect && r_cnt != 16'hFFFF) ? r_cnt + 16'd1 : r_cnt;
    end
  end
  assign pc_out          = r_pc;
  assign if_id_instr     = r_instr;
  assign if_id_pc_plus_4 = r_pc4;
  assign if_id_valid     = r_valid;
  assign redirect_count  = r_cnt;
endmodule

// File: tb/tb_pc_if_id.sv
// tb_pc_if_id: directed self-checking bench for pc_if_id.
module tb_pc_if_id;
  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] instr_mem_data = 32'h2008_0001, jump_target = 32'h0, branch_target = 32'h0;
  logic        stall = 1'b0, jump_taken = 1'b0, branch_taken = 1'b0;
  logic [31:0] pc_out, if_id_instr, if_id_pc_plus_4;
  logic        if_id_valid;
  logic [15:0] redirect_count;
  int n_chk = 0, n_fail = 0;
`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  pc_if_id dut (
    .clock(clock), .reset(reset), .instr_mem_data(instr_mem_data), .stall(stall),
    .jump_taken(jump_taken), .jump_target(jump_target), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_out(pc_out), .if_id_instr(if_id_instr),
    .if_id_pc_plus_4(if_id_pc_plus_4), .if_id_valid(if_id_valid), .redirect_count(redirect_count)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    step();
    step();
    n_chk++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0); end
    n_chk++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", if_id_instr, 32'h0); end
    n_chk++; if (if_id_pc_plus_4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want %h", if_id_pc_plus_4, 32'h0); end
    n_chk++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    n_chk++; if (redirect_count !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0000", redirect_count); end
  endtask
  task automatic test_sequential();
    reset = 1'b0;
    jump_taken = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0500;
    step();
    n_chk++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL boot_pc: got %h want %h", pc_out, 32'h0); end
    n_chk++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b want 0", if_id_valid); end
    n_chk++; if (redirect_count !== 16'h0) begin n_fail++; $display("FAIL boot_cnt: got %h want 0000", redirect_count); end
    jump_taken = 1'b0;
    branch_taken = 1'b0;
    step();
    n_chk++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL seq1_pc: got %h want %h", pc_out, 32'h4); end
    n_chk++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL seq1_valid: got %b want 1", if_id_valid); end
    n_chk++; if (if_id_pc_plus_4 !== 32'h4) begin n_fail++; $display("FAIL seq1_pc4: got %h want %h", if_id_pc_plus_4, 32'h4); end
    n_chk++; if (if_id_instr !== 32'h2008_0001) begin n_fail++; $display("FAIL seq1_instr: got %h want %h", if_id_instr, 32'h2008_0001); end
    step();
    n_chk++; if (pc_out !== 32'h8) begin n_fail++; $display("FAIL seq2_pc: got %h want %h", pc_out, 32'h8); end
    n_chk++; if (if_id_pc_plus_4 !== 32'h8) begin n_fail++; $display("FAIL seq2_pc4: got %h want %h", if_id_pc_plus_4, 32'h8); end
  endtask
  task automatic test_jump();
    step();
    step();
    n_chk++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL pre_jump_pc: got %h want %h", pc_out, 32'h10); end
    instr_mem_data = 32'hAAAA_0010;
    jump_taken = 1'b1;
    jump_target = 32'h0040_0000;
    step();
    jump_taken = 1'b0;
    n_chk++; if (pc_out !== 32'h0040_0000) begin n_fail++; $display("FAIL jump_pc: got %h want %h", pc_out, 32'h0040_0000); end
    n_chk++; if (if_id_instr !== (DS ? 32'hAAAA_0010 : 32'h0)) begin n_fail++; $display("FAIL jump_instr: got %h want %h", if_id_instr, DS ? 32'hAAAA_0010 : 32'h0); end
    n_chk++; if (if_id_valid !== DS) begin n_fail++; $display("FAIL jump_valid: got %b want %b", if_id_valid, DS); end
    n_chk++; if (if_id_pc_plus_4 !== 32'h14) begin n_fail++; $display("FAIL jump_pc4: got %h want %h", if_id_pc_plus_4, 32'h14); end
    n_chk++; if (redirect_count !== 16'h1) begin n_fail++; $display("FAIL jump_cnt: got %h want 0001", redirect_count); end
  endtask
  task automatic test_stall_jump();
    step();
    n_chk++; if (pc_out !== 32'h0040_0004) begin n_fail++; $display("FAIL after_jump_pc: got %h want %h", pc_out, 32'h0040_0004); end
    stall = 1'b1;
    jump_taken = 1'b1;
    jump_target = 32'h0000_2000;
    instr_mem_data = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++; if (pc_out !== 32'h0040_0004) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc_out, 32'h0040_0004); end
      n_chk++; if (if_id_instr !== 32'hAAAA_0010) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", i, if_id_instr, 32'hAAAA_0010); end
      n_chk++; if (if_id_pc_plus_4 !== 32'h0040_0004) begin n_fail++; $display("FAIL stall_pc4[%0d]: got %h want %h", i, if_id_pc_plus_4, 32'h0040_0004); end
      n_chk++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, if_id_valid); end
      n_chk++; if (redirect_count !== 16'h1) begin n_fail++; $display("FAIL stall_cnt[%0d]: got %h want 0001", i, redirect_count); end
    end
    stall = 1'b0;
    step();
    jump_taken = 1'b0;
    n_chk++; if (pc_out !== 32'h0000_2000) begin n_fail++; $display("FAIL unstall_pc: got %h want %h", pc_out, 32'h0000_2000); end
    n_chk++; if (if_id_pc_plus_4 !== 32'h0040_0008) begin n_fail++; $display("FAIL unstall_pc4: got %h want %h", if_id_pc_plus_4, 32'h0040_0008); end
    n_chk++; if (if_id_valid !== DS) begin n_fail++; $display("FAIL unstall_valid: got %b want %b", if_id_valid, DS); end
    n_chk++; if (redirect_count !== 16'h2) begin n_fail++; $display("FAIL unstall_cnt: got %h want 0002", redirect_count); end
  endtask
  task automatic test_branch_priority();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0100;
    stall = 1'b1;
    jump_taken = 1'b1;
    jump_target = 32'h0000_3000;
    step();
    branch_taken = 1'b0;
    stall = 1'b0;
    jump_taken = 1'b0;
    n_chk++; if (pc_out !== 32'h0000_0100) begin n_fail++; $display("FAIL branch_pc: got %h want %h", pc_out, 32'h0000_0100); end
    n_chk++; if (if_id_pc_plus_4 !== 32'h0000_2004) begin n_fail++; $display("FAIL branch_pc4: got %h want %h", if_id_pc_plus_4, 32'h0000_2004); end
    n_chk++; if (redirect_count !== 16'h3) begin n_fail++; $display("FAIL branch_cnt: got %h want 0003", redirect_count); end
  endtask
  task automatic test_wrap();
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    n_chk++; if (pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre_pc: got %h want %h", pc_out, 32'hFFFF_FFFC); end
    instr_mem_data = 32'hCAFE_0001;
    step();
    n_chk++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", pc_out, 32'h0); end
    n_chk++; if (if_id_pc_plus_4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h want %h", if_id_pc_plus_4, 32'h0); end
    n_chk++; if (if_id_instr !== 32'hCAFE_0001) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", if_id_instr, 32'hCAFE_0001); end
    n_chk++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b want 1", if_id_valid); end
  endtask
  task automatic test_saturate();
    jump_taken = 1'b1;
    jump_target = 32'h0000_0040;
    for (int i = 0; i < 65530; i++) step();
    n_chk++; if (redirect_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre_cnt: got %h want FFFE", redirect_count); end
    step();
    n_chk++; if (redirect_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt: got %h want FFFF", redirect_count); end
    step();
    n_chk++; if (redirect_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold_cnt: got %h want FFFF", redirect_count); end
    n_chk++; if (pc_out !== 32'h0000_0040) begin n_fail++; $display("FAIL sat_pc: got %h want %h", pc_out, 32'h0000_0040); end
  endtask
  task automatic test_reset_mid_redirect();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0800;
    stall = 1'b1;
    reset = 1'b1;
    step();
    n_chk++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst2_pc: got %h want %h", pc_out, 32'h0); end
    n_chk++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL rst2_instr: got %h want %h", if_id_instr, 32'h0); end
    n_chk++; if (if_id_pc_plus_4 !== 32'h0) begin n_fail++; $display("FAIL rst2_pc4: got %h want %h", if_id_pc_plus_4, 32'h0); end
    n_chk++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst2_valid: got %b want 0", if_id_valid); end
    n_chk++; if (redirect_count !== 16'h0) begin n_fail++; $display("FAIL rst2_cnt: got %h want 0000", redirect_count); end
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_stall_jump();
    test_branch_priority();
    test_wrap();
    test_saturate();
    test_reset_mid_redirect();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_if_id.md
PC_IF_ID -- requirements
Module: pc_if_id

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, bubble instruction (sll $0,$0,0).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr_mem_data  input  32  instruction read combinationally at pc_out.
REQ-006 stall  input  1  hazard-unit request to hold PC and IF/ID.
REQ-007 jump_taken  input  1  ID-stage J/JAL decoded.
REQ-008 jump_target  input  32  jump target computed by the ID-stage jump unit from if_id_pc_plus_4[31:28] and instr[25:0]<<2.
REQ-009 branch_taken  input  1  EX-stage branch resolved taken.
REQ-010 branch_target  input  32  EX-stage branch address.
REQ-011 pc_out  output  32  current fetch address to instruction memory.
REQ-012 if_id_instr  output  32  registered instruction to ID.
REQ-013 if_id_pc_plus_4  output  32  registered fetch PC + 4 to ID and the jump unit.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-015 redirect_count  output  16  number of accepted redirects, saturating.

Function
REQ-016 The block SHALL compute pc_plus_4 = pc_out + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-017 Next-PC priority SHALL be: branch_taken > stall > jump_taken > sequential.
REQ-018 branch_taken=1: PC <= branch_target, regardless of stall or jump_taken.
REQ-019 stall=1 and branch_taken=0: PC, if_id_instr, if_id_pc_plus_4, if_id_valid SHALL hold; jump_taken SHALL be ignored that cycle (jump re-presented when unstalled).
REQ-020 jump_taken=1, stall=0, branch_taken=0: PC <= jump_target.
REQ-021 No request: PC <= pc_plus_4; IF/ID <= {instr_mem_data, pc_plus_4, valid=1}.
REQ-022 Redirect (branch or accepted jump) SHALL load IF/ID per REQ-031/REQ-032 in the same edge as the PC update.
REQ-023 Redirect latency: new target SHALL appear on pc_out exactly one cycle after the request cycle; its instruction reaches IF/ID one cycle later.
REQ-024 Internal state machine SHALL have states BOOT and RUN; reset enters BOOT; BOOT SHALL fetch RESET_PC and go to RUN unconditionally on the next edge unless reset.
REQ-025 In BOOT, stall, jump_taken and branch_taken SHALL be ignored; if_id_valid SHALL be 0.
REQ-026 redirect_count SHALL increment by 1 on each edge where a redirect is accepted, saturate at 16'hFFFF, and never wrap.
REQ-027 pc_out SHALL be driven directly by the PC register (no combinational path from inputs).

Reset
REQ-028 On reset: pc_out=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus_4=32'h0, if_id_valid=0, redirect_count=0, state=BOOT.
REQ-029 Reset SHALL override stall, jump_taken and branch_taken in the same cycle, including mid-redirect.
REQ-030 Deassertion SHALL take effect on the first rising edge with reset=0; no asynchronous behaviour.

Configuration
REQ-031 Macro DELAY_SLOT_EN undefined: on redirect IF/ID SHALL load a bubble (NOP_INSTR, pc_plus_4 unchanged as computed, valid=0), squashing the instruction fetched after the jump/branch.
REQ-032 Macro DELAY_SLOT_EN defined: on redirect IF/ID SHALL load the fetched instruction normally (valid=1), implementing one MIPS delay slot; all other behaviour identical.

Verification
REQ-033 Reset, then 3 unstalled cycles with instr_mem_data=32'h2008_0001 -> pc_out 0,0(BOOT),4,8; if_id_valid 0 then 1; if_id_pc_plus_4=4 on first valid.
REQ-034 PC=32'h0000_0010, jump_taken=1, jump_target=32'h0040_0000 -> next pc_out=32'h0040_0000; IF/ID bubble (no macro) or instr at 0x10 with valid=1 (DELAY_SLOT_EN); redirect_count +1.
REQ-035 stall=1 and jump_taken=1 for 2 cycles, then stall=0 -> PC and IF/ID frozen 2 cycles, jump accepted on third; redirect_count +1 only.
REQ-036 branch_taken=1 target 32'h0000_0100 with stall=1 and jump_taken=1 simultaneously -> pc_out=32'h0000_0100.
REQ-037 PC=32'hFFFF_FFFC sequential -> pc_out=32'h0000_0000, if_id_pc_plus_4=32'h0000_0000.
REQ-038 Force redirect_count to 16'hFFFF via 65535 jumps, then one more -> stays 16'hFFFF; reset asserted during a redirect cycle -> all outputs at REQ-028 values next edge.
